// File: rtl/csr_file_if.sv
// CSR access bus between the pipeline and the machine-mode CSR file.
//
// Access protocol (there is no valid/ready pair; both ports are single-cycle):
//   write: csr_we_i qualifies csr_waddr_i/csr_wdata_i for exactly the next
//          rising clk edge; there is no back-pressure, so a write always lands.
//   read : csr_raddr_i is sampled combinationally; csr_rdata_o and
//          csr_illegal_o answer in the same cycle, including the bypass of a
//          write that is landing on the same address at the coming edge.
//   retire: instret_incr_i is a one-cycle pulse per retired instruction.
interface csr_file_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int CSR_ADDR_WIDTH = 12
);
    logic                      csr_we_i;
    logic [CSR_ADDR_WIDTH-1:0] csr_waddr_i;
    logic [DATA_WIDTH-1:0]     csr_wdata_i;
    logic                      instret_incr_i;
    logic [CSR_ADDR_WIDTH-1:0] csr_raddr_i;
    logic [DATA_WIDTH-1:0]     csr_rdata_o;
    logic                      csr_illegal_o;

    // Pipeline side: drives accesses, consumes read data.
    modport master (
        output csr_we_i, csr_waddr_i, csr_wdata_i, instret_incr_i, csr_raddr_i,
        input  csr_rdata_o, csr_illegal_o
    );

    // CSR file side.
    modport slave (
        input  csr_we_i, csr_waddr_i, csr_wdata_i, instret_incr_i, csr_raddr_i,
        output csr_rdata_o, csr_illegal_o
    );
endinterface

// File: rtl/csr_file.sv
// Machine-mode CSR file: WARL-masked trap CSRs, 64-bit mcycle/minstret
// counters with split-half writes, read-only user shadows, and a same-cycle
// write-to-read bypass. There is no FSM; all state lives in regs_q, which is
// visible as a single struct for checkers.
module csr_file #(
    parameter int DATA_WIDTH     = 32,
    parameter int CSR_ADDR_WIDTH = 12
) (
    input  logic         clk_i,
    input  logic         rst_i,
    csr_file_if.slave    csr_bus
);
    localparam int DW = DATA_WIDTH;
    localparam int CW = 2 * DATA_WIDTH;

    typedef logic [CSR_ADDR_WIDTH-1:0] addr_t;

    localparam addr_t A_MVENDORID = addr_t'(12'hF11);
    localparam addr_t A_MARCHID   = addr_t'(12'hF12);
    localparam addr_t A_MIMPID    = addr_t'(12'hF13);
    localparam addr_t A_MHARTID   = addr_t'(12'hF14);
    localparam addr_t A_MSTATUS   = addr_t'(12'h300);
    localparam addr_t A_MISA      = addr_t'(12'h301);
    localparam addr_t A_MIE       = addr_t'(12'h304);
    localparam addr_t A_MTVEC     = addr_t'(12'h305);
    localparam addr_t A_MSCRATCH  = addr_t'(12'h340);
    localparam addr_t A_MEPC      = addr_t'(12'h341);
    localparam addr_t A_MCAUSE    = addr_t'(12'h342);
    localparam addr_t A_MTVAL     = addr_t'(12'h343);
    localparam addr_t A_MIP       = addr_t'(12'h344);
    localparam addr_t A_MCYCLE    = addr_t'(12'hB00);
    localparam addr_t A_MINSTRET  = addr_t'(12'hB02);
    localparam addr_t A_MCYCLEH   = addr_t'(12'hB80);
    localparam addr_t A_MINSTRETH = addr_t'(12'hB82);
    localparam addr_t A_CYCLE     = addr_t'(12'hC00);
    localparam addr_t A_INSTRET   = addr_t'(12'hC02);
    localparam addr_t A_CYCLEH    = addr_t'(12'hC80);
    localparam addr_t A_INSTRETH  = addr_t'(12'hC82);

    localparam logic [DW-1:0] MISA_VALUE = DW'(32'h4000_0100);

    // Only the bits that can actually change are stored; constant fields
    // (MPP, misa, mip, low bits of mtvec/mepc) are rebuilt in read_view.
    typedef struct packed {
        logic          st_mie;
        logic          st_mpie;
        logic [2:0]    irq_en;     // mie bits {11, 7, 3}
        logic [DW-3:0] mtvec;      // mtvec[DW-1:2]
        logic [DW-1:0] mscratch;
        logic [DW-3:0] mepc;       // mepc[DW-1:2]
        logic [DW-1:0] mcause;
        logic [DW-1:0] mtval;
        logic [CW-1:0] mcycle;
        logic [CW-1:0] minstret;
    } csr_regs_t;

    csr_regs_t     regs_q;
    csr_regs_t     regs_d;
    logic [CW-1:0] cyc_inc;
    logic [CW-1:0] ins_inc;
    logic [DW:0]   rd_cur;
    logic [DW:0]   rd_nxt;
    logic [DW:0]   rd_sel;
    logic          bypass;

    // Addresses whose stored value a write can change, and hence the only
    // addresses eligible for the read bypass. Shadows and ID CSRs are excluded.
    function automatic logic is_writable(input addr_t a);
        logic w;
        w = 1'b0;
        case (a)
            A_MSTATUS, A_MISA, A_MIE, A_MTVEC, A_MSCRATCH, A_MEPC, A_MCAUSE,
            A_MTVAL, A_MIP, A_MCYCLE, A_MINSTRET, A_MCYCLEH, A_MINSTRETH:
                w = 1'b1;
            default: w = 1'b0;
        endcase
        return w;
    endfunction

    // Architectural view of a register set at address a: {hit, data}.
    function automatic logic [DW:0] read_view(input csr_regs_t r, input addr_t a);
        logic [DW-1:0] d;
        logic          hit;
        d   = '0;
        hit = 1'b1;
        case (a)
            A_MVENDORID, A_MARCHID, A_MIMPID, A_MHARTID, A_MIP: d = '0;
            A_MSTATUS: begin
                d[3]     = r.st_mie;
                d[7]     = r.st_mpie;
                d[12:11] = 2'b11;
            end
            A_MISA:     d = MISA_VALUE;
            A_MIE: begin
                d[3]  = r.irq_en[0];
                d[7]  = r.irq_en[1];
                d[11] = r.irq_en[2];
            end
            A_MTVEC:    d = {r.mtvec, 2'b00};
            A_MSCRATCH: d = r.mscratch;
            A_MEPC:     d = {r.mepc, 2'b00};
            A_MCAUSE:   d = r.mcause;
            A_MTVAL:    d = r.mtval;
            A_MCYCLE,   A_CYCLE:    d = r.mcycle[DW-1:0];
            A_MCYCLEH,  A_CYCLEH:   d = r.mcycle[CW-1:DW];
            A_MINSTRET, A_INSTRET:  d = r.minstret[DW-1:0];
            A_MINSTRETH, A_INSTRETH: d = r.minstret[CW-1:DW];
            default: begin
                d   = '0;
                hit = 1'b0;
            end
        endcase
        return {hit, d};
    endfunction

    // Next state: counters advance, then a write overrides the half it hits.
    always_comb begin
        cyc_inc = regs_q.mcycle + CW'(1);
        ins_inc = regs_q.minstret + CW'(csr_bus.instret_incr_i);
        regs_d          = regs_q;
        regs_d.mcycle   = cyc_inc;
        regs_d.minstret = ins_inc;
        if (csr_bus.csr_we_i) begin
            case (csr_bus.csr_waddr_i)
                A_MSTATUS: begin
                    regs_d.st_mie  = csr_bus.csr_wdata_i[3];
                    regs_d.st_mpie = csr_bus.csr_wdata_i[7];
                end
                A_MIE: regs_d.irq_en = {csr_bus.csr_wdata_i[11],
                                        csr_bus.csr_wdata_i[7],
                                        csr_bus.csr_wdata_i[3]};
                A_MTVEC:    regs_d.mtvec    = csr_bus.csr_wdata_i[DW-1:2];
                A_MSCRATCH: regs_d.mscratch = csr_bus.csr_wdata_i;
                A_MEPC:     regs_d.mepc     = csr_bus.csr_wdata_i[DW-1:2];
                A_MCAUSE:   regs_d.mcause   = csr_bus.csr_wdata_i;
                A_MTVAL:    regs_d.mtval    = csr_bus.csr_wdata_i;
                // Low-half write: high half frozen, no carry into it.
                A_MCYCLE:    regs_d.mcycle   = {regs_q.mcycle[CW-1:DW], csr_bus.csr_wdata_i};
                A_MINSTRET:  regs_d.minstret = {regs_q.minstret[CW-1:DW], csr_bus.csr_wdata_i};
                // High-half write: low half still counts, its carry is dropped.
                A_MCYCLEH:   regs_d.mcycle   = {csr_bus.csr_wdata_i, cyc_inc[DW-1:0]};
                A_MINSTRETH: regs_d.minstret = {csr_bus.csr_wdata_i, ins_inc[DW-1:0]};
                default: ;
            endcase
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            regs_q <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    // Zero-latency read; a write landing on the read address is forwarded
    // from the next-state view so the masking matches what gets stored.
    always_comb begin
        rd_cur = read_view(regs_q, csr_bus.csr_raddr_i);
        rd_nxt = read_view(regs_d, csr_bus.csr_raddr_i);
        bypass = csr_bus.csr_we_i
                 && (csr_bus.csr_waddr_i == csr_bus.csr_raddr_i)
                 && is_writable(csr_bus.csr_raddr_i);
        rd_sel = bypass ? rd_nxt : rd_cur;
    end

    assign csr_bus.csr_rdata_o   = rd_sel[DW-1:0];
    assign csr_bus.csr_illegal_o = ~rd_sel[DW];

endmodule
